cc_threshold_comparator: RTL

//  Multi-channel, mode-selectable magnitude comparator with registered outputs and per-channel persistence filter.

---
 rtl/cc_threshold_comparator_pkg.sv | 41 ++++
 rtl/cc_threshold_comparator_if.sv | 35 +++
 rtl/cc_threshold_comparator_channel.sv | 76 +++++++
 rtl/cc_threshold_comparator.sv | 55 +++++
 4 files changed

// File: rtl/cc_threshold_comparator_pkg.sv
// rtl/cc_threshold_comparator_pkg.sv - compare mode constants and compare helper
// Package cc_threshcmp_pkg: mode encodings and cmp_eval(a, b, mode).
// Build option: CC_THRESHCMP_SIGNED_EN makes the ordered modes (LT/LE/GT/GE) signed.
// Operands are widened by the caller to CMP_OPND_W bits, so the helper is width-agnostic.
package cc_threshcmp_pkg;

  localparam int CMP_MODE_W = 3;
  localparam int CMP_OPND_W = 64;

  localparam logic [CMP_MODE_W-1:0] CMP_LT = 3'd0;
  localparam logic [CMP_MODE_W-1:0] CMP_LE = 3'd1;
  localparam logic [CMP_MODE_W-1:0] CMP_GT = 3'd2;
  localparam logic [CMP_MODE_W-1:0] CMP_GE = 3'd3;
  localparam logic [CMP_MODE_W-1:0] CMP_EQ = 3'd4;
  localparam logic [CMP_MODE_W-1:0] CMP_NE = 3'd5;

  typedef logic [CMP_OPND_W-1:0] cmp_opnd_t;

  // Returns (a OP b); the reserved modes 6/7 always give 0.
  function automatic logic cmp_eval(input cmp_opnd_t a, input cmp_opnd_t b,
                                    input logic [CMP_MODE_W-1:0] mode);
    logic isLt;
    logic isEq;
`ifdef CC_THRESHCMP_SIGNED_EN
    isLt = $signed(a) < $signed(b);
`else
    isLt = a < b;
`endif
    isEq = (a == b);
    case (mode)
      CMP_LT:  cmp_eval = isLt;
      CMP_LE:  cmp_eval = isLt | isEq;
      CMP_GT:  cmp_eval = ~(isLt | isEq);
      CMP_GE:  cmp_eval = ~isLt;
      CMP_EQ:  cmp_eval = isEq;
      CMP_NE:  cmp_eval = ~isEq;
      default: cmp_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cc_threshold_comparator_if.sv
// rtl/cc_threshold_comparator_if.sv - sample/result bus of the threshold comparator
// Interface cc_threshold_comparator_if
//   master: drives clear_In, valid_In, mode_InBUS, data_InBUS, thresh_InBUS; reads outputs
//   slave : the comparator; drives valid_Out, result_OutBUS, flag_OutBUS, rise_OutBUS
interface cc_threshold_comparator_if #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int NUMBER_CHANNELS  = 4
);
  import cc_threshcmp_pkg::*;

  logic                                      CC_THRESHCMP_clear_In;
  logic                                      CC_THRESHCMP_valid_In;
  logic [CMP_MODE_W-1:0]                     CC_THRESHCMP_mode_InBUS;
  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0] CC_THRESHCMP_data_InBUS;
  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0] CC_THRESHCMP_thresh_InBUS;
  logic                                      CC_THRESHCMP_valid_Out;
  logic [NUMBER_CHANNELS-1:0]                CC_THRESHCMP_result_OutBUS;
  logic [NUMBER_CHANNELS-1:0]                CC_THRESHCMP_flag_OutBUS;
  logic [NUMBER_CHANNELS-1:0]                CC_THRESHCMP_rise_OutBUS;

  modport master (
    output CC_THRESHCMP_clear_In, CC_THRESHCMP_valid_In, CC_THRESHCMP_mode_InBUS,
           CC_THRESHCMP_data_InBUS, CC_THRESHCMP_thresh_InBUS,
    input  CC_THRESHCMP_valid_Out, CC_THRESHCMP_result_OutBUS,
           CC_THRESHCMP_flag_OutBUS, CC_THRESHCMP_rise_OutBUS
  );

  modport slave (
    input  CC_THRESHCMP_clear_In, CC_THRESHCMP_valid_In, CC_THRESHCMP_mode_InBUS,
           CC_THRESHCMP_data_InBUS, CC_THRESHCMP_thresh_InBUS,
    output CC_THRESHCMP_valid_Out, CC_THRESHCMP_result_OutBUS,
           CC_THRESHCMP_flag_OutBUS, CC_THRESHCMP_rise_OutBUS
  );

endinterface

// File: rtl/cc_threshold_comparator_channel.sv
// rtl/cc_threshold_comparator_channel.sv - one comparator channel with persistence filter
// Module cc_threshcmp_channel
//   clk, rst        : clock, synchronous active-high reset
//   clear, valid    : synchronous clear, sample strobe
//   mode, data, thresh : compare operation and operands
//   result          : registered raw compare result
//   flag            : raw result filtered over NUMBER_PERSIST consecutive samples
//   rise            : one-cycle pulse on flag 0->1
// Build option: CC_THRESHCMP_SIGNED_EN selects two's complement operands.
module cc_threshcmp_channel
  import cc_threshcmp_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int NUMBER_PERSIST   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        valid,
  input  logic [CMP_MODE_W-1:0]       mode,
  input  logic [NUMBER_DATAWIDTH-1:0] data,
  input  logic [NUMBER_DATAWIDTH-1:0] thresh,
  output logic                        result,
  output logic                        flag,
  output logic                        rise
);

  localparam int NUMBER_CNTWIDTH = $clog2(NUMBER_PERSIST + 1);
  localparam logic [NUMBER_CNTWIDTH-1:0] CNT_LAST = NUMBER_CNTWIDTH'(NUMBER_PERSIST - 1);

  logic [NUMBER_CNTWIDTH-1:0] cnt;
  cmp_opnd_t                  dataExt;
  cmp_opnd_t                  threshExt;
  logic                       raw;

  // Widening keeps the sign in the signed build so the wide compare matches the narrow one.
  always_comb begin
`ifdef CC_THRESHCMP_SIGNED_EN
    dataExt   = CMP_OPND_W'($signed(data));
    threshExt = CMP_OPND_W'($signed(thresh));
`else
    dataExt   = CMP_OPND_W'(data);
    threshExt = CMP_OPND_W'(thresh);
`endif
    raw = cmp_eval(dataExt, threshExt, mode);
  end

  // cnt counts consecutive valid samples that disagree with flag; it never passes CNT_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      flag   <= 1'b0;
      rise   <= 1'b0;
      result <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      flag <= 1'b0;
      rise <= 1'b0;
    end else if (valid) begin
      result <= raw;
      rise   <= 1'b0;
      if (raw == flag) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        flag <= raw;
        rise <= raw;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      rise <= 1'b0;
    end
  end

endmodule

// File: rtl/cc_threshold_comparator.sv
// rtl/cc_threshold_comparator.sv - multi-channel threshold comparator top
// Module cc_threshold_comparator
//   CC_THRESHCMP_CLOCK_50     : clock
//   CC_THRESHCMP_RESET_InHigh : synchronous active-high reset
//   bus (slave modport)       : clear/valid/mode/data/thresh in; valid/result/flag/rise out
// Build option: CC_THRESHCMP_SIGNED_EN selects signed ordered comparisons.
module cc_threshold_comparator
  import cc_threshcmp_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int NUMBER_CHANNELS  = 4,
  parameter int NUMBER_PERSIST   = 3
) (
  input  logic                          CC_THRESHCMP_CLOCK_50,
  input  logic                          CC_THRESHCMP_RESET_InHigh,
  cc_threshold_comparator_if.slave      bus
);

  logic                       validOutReg;
  logic [NUMBER_CHANNELS-1:0] resultVec;
  logic [NUMBER_CHANNELS-1:0] flagVec;
  logic [NUMBER_CHANNELS-1:0] riseVec;

  always_ff @(posedge CC_THRESHCMP_CLOCK_50) begin
    if (CC_THRESHCMP_RESET_InHigh || bus.CC_THRESHCMP_clear_In) begin
      validOutReg <= 1'b0;
    end else begin
      validOutReg <= bus.CC_THRESHCMP_valid_In;
    end
  end

  for (genvar c = 0; c < NUMBER_CHANNELS; c++) begin : gCh
    cc_threshcmp_channel #(
      .NUMBER_DATAWIDTH(NUMBER_DATAWIDTH),
      .NUMBER_PERSIST  (NUMBER_PERSIST)
    ) uCh (
      .clk   (CC_THRESHCMP_CLOCK_50),
      .rst   (CC_THRESHCMP_RESET_InHigh),
      .clear (bus.CC_THRESHCMP_clear_In),
      .valid (bus.CC_THRESHCMP_valid_In),
      .mode  (bus.CC_THRESHCMP_mode_InBUS),
      .data  (bus.CC_THRESHCMP_data_InBUS[c*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH]),
      .thresh(bus.CC_THRESHCMP_thresh_InBUS[c*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH]),
      .result(resultVec[c]),
      .flag  (flagVec[c]),
      .rise  (riseVec[c])
    );
  end

  assign bus.CC_THRESHCMP_valid_Out     = validOutReg;
  assign bus.CC_THRESHCMP_result_OutBUS = resultVec;
  assign bus.CC_THRESHCMP_flag_OutBUS   = flagVec;
  assign bus.CC_THRESHCMP_rise_OutBUS   = riseVec;

endmodule
